tt_um_vedic_4x4: RTL and testbench

TT_UM_VEDIC_4X4 -- requirements
Module: tt_um_vedic_4x4

---
 rtl/tt_um_vedic_4x4.sv | 71 +++++++
 tb/tb_tt_um_vedic_4x4.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_vedic_4x4.sv
// 4x4 unsigned Urdhva-Tiryagbhyam (vertical-crosswise) multiplier with a registered 8-bit product.
// Operands arrive on ui_in; the product appears on uo_out one clock after capture while ena is high.
module tt_um_vedic_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // 2x2 Vedic cell: four AND partial products folded by two half adders.
    function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
        logic       pp00, pp10, pp01, pp11;
        logic       s1, c1, s2, c2;
        pp00 = a[0] & b[0];
        pp10 = a[1] & b[0];
        pp01 = a[0] & b[1];
        pp11 = a[1] & b[1];
        s1   = pp10 ^ pp01;
        c1   = pp10 & pp01;
        s2   = pp11 ^ c1;
        c2   = pp11 & c1;
        return {c2, s2, s1, pp00};
    endfunction

    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] q_ll;
    logic [3:0] q_hl;
    logic [3:0] q_lh;
    logic [3:0] q_hh;
    logic [5:0] mid_sum;
    logic [3:0] high_sum;
    logic [7:0] product_d;
    logic [7:0] product_q;

    assign op_a = ui_in[7:4];
    assign op_b = ui_in[3:0];

    assign q_ll = vedic_2x2(op_a[1:0], op_b[1:0]);
    assign q_hl = vedic_2x2(op_a[3:2], op_b[1:0]);
    assign q_lh = vedic_2x2(op_a[1:0], op_b[3:2]);
    assign q_hh = vedic_2x2(op_a[3:2], op_b[3:2]);

    // Crosswise column at weight 2^2: both cross terms plus the upper half of AL*BL.
    assign mid_sum  = {2'b00, q_hl} + {2'b00, q_lh} + {4'b0000, q_ll[3:2]};
    // Vertical column at weight 2^4: AH*BH plus the carry-out of the crosswise column.
    assign high_sum = q_hh + mid_sum[5:2];

    assign product_d = {high_sum, mid_sum[1:0], q_ll[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= 8'h00;
        end else if (ena) begin
            product_q <= product_d;
        end
    end

    assign uo_out  = product_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // The bidirectional pins are inputs only and carry nothing this block uses.
    logic unused_uio;
    assign unused_uio = ^uio_in;

endmodule

// File: tb/tb_tt_um_vedic_4x4.sv
// Bench for tt_um_vedic_4x4: driver pushes A*B into exp_q, a monitor pops after each enabled edge.
// Also covers hold with ena low, asynchronous reset mid-cycle, and an exhaustive operand sweep.
module tb_tt_um_vedic_4x4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    tt_um_vedic_4x4 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%02h), required %0d (0x%02h)", tag, got, got, exp, exp);
        end
    endtask

    // driver: operands change on the falling edge, captured on the next rising edge
    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] prod;
        @(negedge clk);
        ena    = 1'b1;
        ui_in  = {a, b};
        uio_in = 8'($urandom_range(0, 255));
        prod   = 8'(a) * 8'(b);
        exp_q.push_back(prod);
    endtask

    task automatic idle_cycle(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        ena    = 1'b0;
        ui_in  = {a, b};
        uio_in = 8'($urandom_range(0, 255));
    endtask

    // scoreboard monitor: every enabled, out-of-reset edge consumes one expectation
    always @(posedge clk) begin
        if (rst_n && ena) begin
            #1;
            if (exp_q.size() == 0) begin
                check_eq("underflow", uo_out, 8'hxx);
            end else begin
                check_eq("product", uo_out, exp_q.pop_front());
                check_eq("uio_out", uio_out, 8'h00);
            end
        end
    end

    initial begin
        logic [7:0] held;
        int         budget;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;

        #3;
        check_eq("reset_uo_out", uo_out, 8'h00);
        check_eq("reset_uio_out", uio_out, 8'h00);
        check_eq("reset_uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        drive(4'd3, 4'd2);
        drive(4'd3, 4'd2);
        drive(4'd5, 4'd4);
        drive(4'd15, 4'd15);
        drive(4'd9, 4'd0);
        drive(4'd0, 4'd9);
        drive(4'd15, 4'd15);

        // hold: ena low, operands change, output must stay at 225
        held = 8'd225;
        for (int i = 0; i < 3; i++) begin
            idle_cycle(4'd2, 4'd3);
            #1;
            check_eq("hold", uo_out, held);
        end
        drive(4'd2, 4'd3);

        drive(4'd15, 4'd15);
        idle_cycle(4'd15, 4'd15);
        #1;
        check_eq("pre_reset", uo_out, 8'd225);

        // asynchronous reset between edges, then an enabled edge while still in reset
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", uo_out, 8'h00);
        check_eq("async_reset_oe", uio_oe, 8'h00);
        ena   = 1'b1;
        ui_in = {4'd7, 4'd7};
        @(posedge clk);
        #1;
        check_eq("reset_priority", uo_out, 8'h00);
        @(negedge clk);
        ena   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_release_no_ena", uo_out, 8'h00);
        drive(4'd7, 4'd7);

        // exhaustive sweep with random uio_in on every cycle
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(4'(a), 4'(b));
            end
        end

        // random back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        idle_cycle(4'd0, 4'd0);
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            check_eq("drain", 8'(exp_q.size()), 8'd0);
        end
        check_eq("final_uio_oe", uio_oe, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
